burst_pattern_generator: RTL and testbench
==========================================

// Module: burst_pattern_generator
// PURPOSE
// Parametrised successor of the button-triggered data generator feeding core_ft245 tx side.
// Debounces a push-button and emits bursts of test words into the FT245 tx FIFO.
// Burst length, pattern mode and one-shot/continuous operation are runtime-selectable.
// It honours FIFO backpressure. Sits in the user clock domain (clk_gen) ahead of core_ft245.
// PARAMETERS
// DATA_W        32          tx word width; multiple of 8, 8..64
// LEN_W         16          width of burst_len / word_count
// DEBOUNCE_CYC  16'd50000   cycles trigger must be stable before accepted (>=2)
// LFSR_SEED     32'h1       LFSR start value; must be non-zero
// PORTS
// clk_in      in   1       user clock; all logic on rising edge
// rst_in      in   1       asynchronous, active-low reset
// trigger     in   1       raw push-button, asynchronous, active-high
// mode        in   2       0 counter, 1 byte ramp, 2 walking one, 3 LFSR
// burst_len   in   LEN_W   words per burst; sampled at burst start
// continuous  in   1       1 = auto-restart bursts until next trigger; sampled at start
// tx_full     in   1       tx FIFO full; no write allowed in that cycle
// tx_data     out  DATA_W  word presented with tx_write
// tx_write    out  1       write strobe to tx FIFO; 1 word per high cycle
// busy        out  1       high while not IDLE
// done        out  1       one-cycle pulse at end of each burst
// word_count  out  LEN_W   words written in current burst
// BEHAVIOUR
// - Reset: state IDLE; tx_write, busy, done 0; tx_data, word_count 0.
//   Pattern reg = 0, LFSR = LFSR_SEED, debounced level 0. Reset mid-burst aborts immediately.
// - Trigger path: 2-FF synchroniser. Debounce counter increments while sync level != debounced level.
//   The counter clears when the levels are equal. At DEBOUNCE_CYC-1 the debounced level takes the sync value.
//   A rising edge of the debounced level produces a one-cycle start pulse.
// - FSM IDLE: on start, latch mode/burst_len/continuous and clear word_count.
//   Pattern state is reset to its mode's initial value. Go to RUN, or DONE if burst_len==0.
// - FSM RUN: tx_write = (state==RUN) & ~tx_full (combinational on tx_full; no extra latency).
//   On each write, word_count+1 and the pattern advances.
//   When the write makes word_count==burst_len, go to DONE. tx_full stalls with no write and no advance.
// - FSM DONE: done=1 for one cycle, tx_write=0.
//   If latched continuous and no start pulse was seen since the burst began, go to RUN:
//   word_count clears and the pattern is NOT reset, so the stream is seamless. Otherwise go to IDLE.
// - Start pulse in RUN: ignored in one-shot. In continuous it is recorded as stop,
//   so the current burst completes and then the FSM returns to IDLE.
// - Patterns (k = index within pattern sequence, lane 0 = bits[7:0]):
//   mode0: k mod 2^DATA_W.  mode1: byte lane i = (k*DATA_W/8 + i) mod 256.
//   mode2: 1 << (k mod DATA_W).
//   mode3: 32-bit Galois LFSR, next = (l>>1) ^ (l[0] ? 32'h80200003 : 0).
//   For mode3, tx_data = LFSR zero-extended/truncated to DATA_W.
// - tx_data is registered and valid whenever tx_write=1. Holds the last value when idle.
// - Latency: trigger rise to first tx_write <= DEBOUNCE_CYC+4 cycles.
// - busy = (state != IDLE). word_count wraps never: burst_len is at most 2^LEN_W-1.
// TESTING
// 1 mode0, len=4, tx_full=0, trigger held > DEBOUNCE_CYC -> 4 consecutive writes 0,1,2,3.
//   Then done pulse for 1 cycle, then busy=0.
// 2 trigger high for DEBOUNCE_CYC-2 cycles, then low (bounce) -> no tx_write, busy stays 0.
// 3 mode0 len=6; tx_full high on 2nd and 3rd RUN cycles -> exactly 6 writes, data 0..5.
//   No tx_write while tx_full is high.
// 4 DATA_W=32: mode1 len=2 gives 0x03020100, 0x07060504.
//   mode2 len=34 gives 1,2,4..0x80000000,1,2.
// 5 mode3 seed 1, len=3 -> 0x00000001, 0x80200003, 0xC0300002.
//   len=0 -> done pulse, no writes.
// 6 continuous, mode0, len=3 -> 0..5 across 2 bursts, 2 done pulses.
//   Second trigger mid-burst -> stop after that burst.
//   rst_in low mid-burst -> tx_write=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/burst_pattern_generator_if.sv
// Transmit-side bus between the burst pattern generator and the FT245 tx FIFO.
//   tx_data  : word offered to the FIFO, valid whenever tx_write is high
//   tx_write : write strobe, one word accepted per high cycle
//   tx_full  : FIFO full, no write may happen in a cycle where it is high
// The master modport is the generator side; the slave modport is the FIFO side.
interface burst_pattern_generator_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_write;
  logic              tx_full;

  modport master (output tx_data, output tx_write, input tx_full);
  modport slave  (input tx_data, input tx_write, output tx_full);
endinterface

// File: rtl/burst_pattern_generator.sv
// Burst pattern generator: debounces a push-button and, on each accepted
// press, writes a burst of test words into the FT245 tx FIFO while honouring
// FIFO backpressure. Burst length, pattern mode and one-shot/continuous
// operation are sampled at the start of each triggered run.
// Ports:
//   clk_in      user clock, rising edge
//   rst_in      asynchronous active-low reset
//   trigger     raw push-button (asynchronous, active-high)
//   mode        0 counter, 1 byte ramp, 2 walking one, 3 LFSR
//   burst_len   words per burst
//   continuous  auto-restart bursts until the next press
//   tx          tx FIFO bus (master side: tx_data, tx_write, tx_full)
//   busy        high while a run is in progress
//   done        one-cycle pulse at the end of each burst
//   word_count  words written in the current burst
module burst_pattern_generator #(
  parameter int          DATA_W       = 32,
  parameter int          LEN_W        = 16,
  parameter int unsigned DEBOUNCE_CYC = 50000,
  parameter logic [31:0] LFSR_SEED    = 32'h1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      trigger,
  input  logic [1:0]                mode,
  input  logic [LEN_W-1:0]          burst_len,
  input  logic                      continuous,
  burst_pattern_generator_if.master tx,
  output logic                      busy,
  output logic                      done,
  output logic [LEN_W-1:0]          word_count
);

  localparam int            DB_W   = $clog2(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0] DB_LIM = DB_W'(DEBOUNCE_CYC - 1);
  localparam int            LANES  = DATA_W / 8;
  localparam int            LW     = (DATA_W < 32) ? DATA_W : 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, next_state;
  logic              sync_a, sync_b, deb_q, start;
  logic [DB_W-1:0]   db_cnt;
  logic [1:0]        mode_q;
  logic [LEN_W-1:0]  len_q;
  logic              cont_q, stop_q;
  logic [DATA_W-1:0] data_q;
  logic [31:0]       lfsr_q, lfsr_nxt;
  logic              wr, last_word;

  // LFSR state zero-extended or truncated to the tx word width.
  function automatic logic [DATA_W-1:0] fit_lfsr(input logic [31:0] l);
    logic [DATA_W-1:0] r;
    r = '0;
    r[LW-1:0] = l[LW-1:0];
    return r;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // First word of a freshly started pattern sequence (k = 0).
  function automatic logic [DATA_W-1:0] pattern_init(input logic [1:0] m);
    logic [DATA_W-1:0] r;
    r = '0;
    case (m)
      2'd0: r = '0;
      2'd1: for (int i = 0; i < LANES; i++) r[8*i +: 8] = 8'(i);
      2'd2: r = DATA_W'(1);
      default: r = fit_lfsr(LFSR_SEED);
    endcase
    return r;
  endfunction

  // Word k+1 derived from word k; the LFSR word comes from the 32-bit state
  // since truncation to narrow words loses information.
  function automatic logic [DATA_W-1:0] pattern_next(input logic [1:0] m,
                                                     input logic [DATA_W-1:0] cur,
                                                     input logic [31:0] lnext);
    logic [DATA_W-1:0] r;
    r = cur;
    case (m)
      2'd0: r = cur + DATA_W'(1);
      2'd1: for (int i = 0; i < LANES; i++) r[8*i +: 8] = cur[8*i +: 8] + 8'(LANES);
      2'd2: r = {cur[DATA_W-2:0], cur[DATA_W-1]};
      default: r = fit_lfsr(lnext);
    endcase
    return r;
  endfunction

  // Trigger synchroniser and debounce: the debounced level follows the
  // synchronised level only after it has differed for DEBOUNCE_CYC cycles.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      deb_q  <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync_a <= trigger;
      sync_b <= sync_a;
      if (sync_b == deb_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LIM) begin
        db_cnt <= '0;
        deb_q  <= sync_b;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Start pulse coincides with the cycle in which the debounced level rises.
  assign start = sync_b && !deb_q && (db_cnt == DB_LIM);

  assign lfsr_nxt  = lfsr_step(lfsr_q);
  assign last_word = (word_count + LEN_W'(1)) == len_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = (burst_len == '0) ? DONE : RUN;
      RUN:  if (wr && last_word) next_state = DONE;
      DONE: begin
        if (cont_q && !stop_q && !start)
          // An empty continuous burst has no write to end it; stay in DONE.
          next_state = (len_q == '0) ? DONE : RUN;
        else
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    wr   = (state == RUN) && !tx.tx_full;
    busy = (state != IDLE);
    done = (state == DONE);
  end

  assign tx.tx_write = wr;
  assign tx.tx_data  = data_q;

  // data_q always holds the word on offer. The final write of a burst does not
  // advance it, so the last written word stays visible after the burst; a
  // continuous restart advances it on the way out of DONE instead.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mode_q     <= 2'd0;
      len_q      <= '0;
      cont_q     <= 1'b0;
      stop_q     <= 1'b0;
      word_count <= '0;
      data_q     <= '0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q     <= mode;
            len_q      <= burst_len;
            cont_q     <= continuous;
            stop_q     <= 1'b0;
            word_count <= '0;
            data_q     <= pattern_init(mode);
            lfsr_q     <= LFSR_SEED;
          end
        end
        RUN: begin
          if (start && cont_q) stop_q <= 1'b1;
          if (wr) begin
            word_count <= word_count + LEN_W'(1);
            if (!last_word) begin
              data_q <= pattern_next(mode_q, data_q, lfsr_nxt);
              lfsr_q <= lfsr_nxt;
            end
          end
        end
        DONE: begin
          if (next_state == RUN) begin
            word_count <= '0;
            data_q     <= pattern_next(mode_q, data_q, lfsr_nxt);
            lfsr_q     <= lfsr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_pattern_generator.sv
// Self-checking bench for burst_pattern_generator (DATA_W=32, short debounce).
// Expected words are pushed to a scoreboard queue when a burst is requested
// and popped by a monitor whenever the DUT writes to the tx FIFO.
`timescale 1ns/1ps
module tb_burst_pattern_generator;
  localparam int          DATA_W = 32;
  localparam int          LEN_W  = 8;
  localparam int unsigned DEB    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             trigger = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [LEN_W-1:0] burst_len = '0;
  logic             continuous = 1'b0;
  logic             busy, done;
  logic [LEN_W-1:0] word_count;

  burst_pattern_generator_if #(.DATA_W(DATA_W)) bus ();

  burst_pattern_generator #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .DEBOUNCE_CYC(DEB), .LFSR_SEED(32'h1)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .trigger(trigger), .mode(mode),
    .burst_len(burst_len), .continuous(continuous), .tx(bus.master),
    .busy(busy), .done(done), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int busy_cyc = 0;
  int wr_cyc [0:511];
  int wr0, d0, b0;
  logic [DATA_W-1:0] sb [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp_v);
    end
  endtask

  // Closed-form reference for word k of each pattern.
  function automatic logic [31:0] exp_word(input int m, input int k);
    logic [31:0] r, l;
    r = '0;
    case (m)
      0: r = 32'(k);
      1: for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'((k * 4 + i) % 256);
      2: r = 32'h1 << (k % 32);
      default: begin
        l = 32'h1;
        for (int j = 0; j < k; j++) l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
        r = l;
      end
    endcase
    return r;
  endfunction

  task automatic push_burst(input int m, input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) sb.push_back(exp_word(m, k));
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (bus.tx_write) begin
        check_eq("wr_while_full", bus.tx_full, 0);
        if (sb.size() == 0) check_eq("sb_underflow", sb.size(), 1);
        else check_eq("tx_data", bus.tx_data, sb.pop_front());
        if (wr_cnt < 512) wr_cyc[wr_cnt] = cyc;
        wr_cnt++;
      end
    end
  end

  task automatic press();
    @(posedge clk); #1 trigger = 1'b1;
    repeat (DEB + 4) @(posedge clk);
    #1 trigger = 1'b0;
    repeat (DEB + 4) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 1000) begin @(negedge clk); n++; end
    if (busy) check_eq({tag, "_timeout"}, busy, 0);
  endtask

  task automatic snap();
    wr0 = wr_cnt; d0 = done_cnt; b0 = busy_cyc;
  endtask

  task automatic run_one(input string tag, input int m, input int len);
    mode = 2'(m); burst_len = LEN_W'(len); continuous = 1'b0;
    push_burst(m, 0, len);
    snap();
    press();
    wait_idle(tag);
    check_eq({tag, "_writes"}, wr_cnt - wr0, len);
    check_eq({tag, "_done"}, done_cnt - d0, 1);
    check_eq({tag, "_sb_left"}, sb.size(), 0);
  endtask

  // Hold tx_full during the 2nd and 3rd RUN cycles.
  task automatic stall_two();
    int n;
    n = 0;
    @(negedge clk);
    while (!busy && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1 bus.tx_full = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.tx_full = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.tx_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx_write", bus.tx_write, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_tx_data", bus.tx_data, 0);
    check_eq("rst_word_count", word_count, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Counter burst, writes on consecutive cycles.
    run_one("t1", 0, 4);
    check_eq("t1_span", wr_cyc[wr_cnt-1] - wr_cyc[wr0], 3);
    check_eq("t1_word_count", word_count, 4);
    check_eq("t1_busy_cycles", busy_cyc - b0, 5);

    // Bounce shorter than the debounce window.
    snap();
    @(posedge clk); #1 trigger = 1'b1;
    repeat (DEB - 2) @(posedge clk);
    #1 trigger = 1'b0;
    repeat (3 * DEB) @(posedge clk);
    #1;
    check_eq("t2_busy", busy_cyc - b0, 0);
    check_eq("t2_writes", wr_cnt - wr0, 0);

    // Backpressure in the middle of a burst.
    mode = 2'd0; burst_len = 8'd6; continuous = 1'b0;
    push_burst(0, 0, 6);
    snap();
    fork
      press();
      stall_two();
    join
    wait_idle("t3");
    check_eq("t3_writes", wr_cnt - wr0, 6);
    check_eq("t3_span", wr_cyc[wr_cnt-1] - wr_cyc[wr0], 7);
    check_eq("t3_done", done_cnt - d0, 1);
    check_eq("t3_sb_left", sb.size(), 0);

    // Byte ramp, walking one (wraps past bit 31), LFSR, empty burst.
    run_one("t4_ramp", 1, 2);
    run_one("t4_walk", 2, 34);
    run_one("t5_lfsr", 3, 3);
    run_one("t5_len0", 3, 0);

    // Continuous bursts, stopped by a second press during burst 2.
    mode = 2'd0; burst_len = 8'd3; continuous = 1'b1;
    push_burst(0, 0, 6);
    snap();
    bus.tx_full = 1'b1;
    press();
    check_eq("t6_started", busy, 1);
    bus.tx_full = 1'b0;
    n = 0;
    while (wr_cnt - wr0 < 4 && n < 200) begin @(posedge clk); #1; n++; end
    check_eq("t6_reach4", wr_cnt - wr0, 4);
    bus.tx_full = 1'b1;
    press();
    bus.tx_full = 1'b0;
    wait_idle("t6");
    check_eq("t6_writes", wr_cnt - wr0, 6);
    check_eq("t6_done", done_cnt - d0, 2);
    check_eq("t6_sb_left", sb.size(), 0);
    check_eq("t6_word_count", word_count, 3);

    // Reset in the middle of a burst.
    mode = 2'd0; burst_len = 8'd20; continuous = 1'b0;
    push_burst(0, 0, 20);
    snap();
    @(posedge clk); #1 trigger = 1'b1;
    n = 0;
    while (wr_cnt - wr0 < 3 && n < 200) begin @(posedge clk); #1; n++; end
    check_eq("t7_pre_rst_write", bus.tx_write, 1);
    rst_n = 1'b0; trigger = 1'b0;
    #1;
    check_eq("t7_tx_write", bus.tx_write, 0);
    check_eq("t7_busy", busy, 0);
    check_eq("t7_done", done, 0);
    check_eq("t7_tx_data", bus.tx_data, 0);
    check_eq("t7_word_count", word_count, 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (DEB + 4) @(posedge clk);
    #1;

    // Normal operation after the aborted burst.
    run_one("t8_after_rst", 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
